// File: rtl/kairo_bus_pkg.sv
// Shared definitions for kairo VALID/READY bus blocks.
package kairo_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } busarb_state_t;

endpackage

// File: rtl/kairo_rr_pick.sv
// Combinational masked priority finder: rotating start in round-robin mode,
// lowest index first in fixed mode.
module kairo_rr_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] start_i,
  input  logic          rr_i,
  output logic [GW-1:0] idx_o,
  output logic          hit_o
);

  int            pos;
  logic [GW-1:0] sel;

  // Scan from the farthest candidate back to the nearest so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = rr_i ? (int'(start_i) + i) % N : i;
      sel = GW'(pos);
      if (req_i[sel]) begin
        idx_o = sel;
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kairo_busarb.sv
// N-master to 1-slave VALID/READY arbiter with registered grant,
// round-robin or fixed priority, and per-transaction timeout.
module kairo_busarb
  import kairo_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int RR_MODE   = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                          RST_N,
  input  logic                          CLK,
  input  logic [N_MASTERS-1:0]          S_VALID,
  output logic [N_MASTERS-1:0]          S_READY,
  input  logic [BUS_SW*N_MASTERS-1:0]   S_WSTB,
  input  logic [BUS_AW*N_MASTERS-1:0]   S_ADDR,
  input  logic [BUS_DW*N_MASTERS-1:0]   S_WDATA,
  output logic [BUS_DW-1:0]             S_RDATA,
  output logic [N_MASTERS-1:0]          S_EXCEPT,
  output logic                          M_VALID,
  input  logic                          M_READY,
  output logic [BUS_SW-1:0]             M_WSTB,
  output logic [BUS_AW-1:0]             M_ADDR,
  output logic [BUS_DW-1:0]             M_WDATA,
  input  logic [BUS_DW-1:0]             M_RDATA,
  input  logic                          M_EXCEPT
);

  localparam int          GW      = $clog2(N_MASTERS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  busarb_state_t  state_q;
  logic [GW-1:0]  grant_q, rr_ptr_q, rr_ptr_d;
  logic [15:0]    tcnt_q;
  logic [GW-1:0]  win;
  logic           any_req;
  logic           busy, done, tmo, finish;

  logic [BUS_AW-1:0] addr_a  [N_MASTERS];
  logic [BUS_SW-1:0] wstb_a  [N_MASTERS];
  logic [BUS_DW-1:0] wdata_a [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = S_ADDR[BUS_AW*i +: BUS_AW];
    assign wstb_a[i]  = S_WSTB[BUS_SW*i +: BUS_SW];
    assign wdata_a[i] = S_WDATA[BUS_DW*i +: BUS_DW];
  end

  kairo_rr_pick #(.N(N_MASTERS), .GW(GW)) u_pick (
    .req_i   (S_VALID),
    .start_i (rr_ptr_q),
    .rr_i    (RR_MODE != 0),
    .idx_o   (win),
    .hit_o   (any_req)
  );

  assign busy     = (state_q == BUSY);
  assign done     = busy && M_READY;
  // Slave completion takes precedence over a timeout in the same cycle.
  assign tmo      = busy && !M_READY && (TIMEOUT != 0) && (tcnt_q == TO_LAST);
  assign finish   = done || tmo;
  assign rr_ptr_d = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + GW'(1);

  // Request mux to the slave and same-cycle response steering to the granted master.
  always_comb begin
    M_VALID  = busy;
    M_ADDR   = '0;
    M_WSTB   = '0;
    M_WDATA  = '0;
    S_READY  = '0;
    S_EXCEPT = '0;
    S_RDATA  = '0;
    if (busy) begin
      M_ADDR  = addr_a[grant_q];
      M_WSTB  = wstb_a[grant_q];
      M_WDATA = wdata_a[grant_q];
    end
    if (finish) begin
      S_READY[grant_q]  = 1'b1;
      S_EXCEPT[grant_q] = done ? M_EXCEPT : 1'b1;
      S_RDATA           = done ? M_RDATA : '0;
    end
  end

  // Arbitration FSM: grant in IDLE, hold until slave READY or timeout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      tcnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= win;
            tcnt_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            state_q <= IDLE;
            if (RR_MODE != 0) rr_ptr_q <= rr_ptr_d;
          end else if (tcnt_q != 16'hFFFF) begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kairo_busarb.sv
// Randomized scoreboard bench: one round-robin instance and one fixed-priority
// instance, each with its own masters, slave and transaction-level model.
module tb_kairo_busarb;

  localparam int NM = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   req_rate = 0;
  logic end_chk  = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } req_t;

  typedef struct {
    int          m;
    logic        e;
    logic [31:0] r;
  } rsp_t;

  task automatic check(input int inst, input string name,
                       input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, name, got, exp, $time);
    end
  endtask

  // Mostly short waits, some long enough to trip the timeout, a few that never answer.
  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return $urandom_range(0, 3);
    if (r < 95) return $urandom_range(4, 12);
    return 200;
  endfunction

  for (genvar G = 0; G < 2; G++) begin : g_i
    localparam int RR = (G == 0) ? 1 : 0;
    localparam int TO = (G == 0) ? 8 : 5;

    logic [NM-1:0]    S_VALID, S_READY, S_EXCEPT;
    logic [4*NM-1:0]  S_WSTB;
    logic [32*NM-1:0] S_ADDR, S_WDATA;
    logic [31:0]      S_RDATA, M_ADDR, M_WDATA, M_RDATA;
    logic [3:0]       M_WSTB;
    logic             M_VALID, M_READY, M_EXCEPT;

    req_t q_req[$];
    rsp_t q_rsp[$];
    logic exp_mv = 1'b0;
    logic exp_sr = 1'b0;
    logic fin    = 1'b0;

    kairo_busarb #(.N_MASTERS(NM), .RR_MODE(RR), .TIMEOUT(TO)) dut (
      .RST_N(RST_N), .CLK(CLK),
      .S_VALID(S_VALID), .S_READY(S_READY), .S_WSTB(S_WSTB), .S_ADDR(S_ADDR),
      .S_WDATA(S_WDATA), .S_RDATA(S_RDATA), .S_EXCEPT(S_EXCEPT),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_WSTB(M_WSTB), .M_ADDR(M_ADDR),
      .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_EXCEPT(M_EXCEPT)
    );

    // Masters hold a request until served; slave answers after a random wait.
    initial begin : drv
      logic [NM-1:0] act, seen;
      int scnt, swait;
      act = '0; seen = '0; scnt = 0; swait = 0;
      S_VALID = '0; S_WSTB = '0; S_ADDR = '0; S_WDATA = '0;
      M_READY = 1'b0; M_RDATA = '0; M_EXCEPT = 1'b0;
      forever begin
        @(negedge CLK);
        seen = S_READY;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NM; i++) begin
          if (!RST_N) act[i] = 1'b0;
          else begin
            if (act[i] && seen[i]) act[i] = 1'b0;
            if (!act[i] && $urandom_range(0, 99) < req_rate) begin
              act[i]             = 1'b1;
              S_ADDR[32*i +: 32]  = $urandom;
              S_WDATA[32*i +: 32] = $urandom;
              S_WSTB[4*i +: 4]    = 4'($urandom_range(0, 15));
            end
          end
        end
        S_VALID  = act;
        M_RDATA  = $urandom;
        M_EXCEPT = ($urandom_range(0, 3) == 0);
        if (!RST_N || !M_VALID) begin
          M_READY = RST_N && ($urandom_range(0, 9) == 0);
          scnt    = 0;
          swait   = pick_wait();
        end else if (scnt == swait) begin
          M_READY = 1'b1;
        end else begin
          M_READY = 1'b0;
          scnt++;
        end
      end
    end

    // Transaction-level reference: who is served next, and how each transaction ends.
    initial begin : mdl
      bit busy;
      int owner, cyc, ptr, w, idx;
      busy = 0; owner = 0; cyc = 0; ptr = 0;
      forever begin
        @(negedge CLK);
        if (!RST_N) begin
          busy = 0; ptr = 0; cyc = 0;
          q_req.delete(); q_rsp.delete();
          exp_mv = 1'b0; exp_sr = 1'b0;
        end else if (!busy) begin
          exp_mv = 1'b0; exp_sr = 1'b0;
          w = -1;
          for (int k = 0; k < NM; k++) begin
            idx = (RR != 0) ? (ptr + k) % NM : k;
            if (w < 0 && S_VALID[idx]) w = idx;
          end
          if (w >= 0) begin
            q_req.push_back('{S_ADDR[32*w +: 32], S_WSTB[4*w +: 4], S_WDATA[32*w +: 32]});
            busy = 1; owner = w; cyc = 0;
          end
        end else begin
          exp_mv = 1'b1; exp_sr = 1'b0;
          cyc++;
          if (M_READY) begin
            q_rsp.push_back('{owner, M_EXCEPT, M_RDATA});
            exp_sr = 1'b1;
          end else if (TO != 0 && cyc == TO) begin
            q_rsp.push_back('{owner, 1'b1, 32'h0});
            exp_sr = 1'b1;
          end
          if (exp_sr) begin
            busy = 0;
            if (RR != 0) ptr = (owner + 1) % NM;
          end
        end
      end
    end

    // Monitor: pops expectations when the DUT issues a request or a response.
    initial begin : mon
      logic pv;
      req_t r;
      rsp_t s;
      pv = 1'b0;
      forever begin
        @(negedge CLK);
        #1;
        check(G, "m_valid", M_VALID, exp_mv);
        check(G, "s_ready_any", |S_READY, exp_sr);
        if (M_VALID && !pv) begin
          check(G, "req_expected", q_req.size() != 0, 1);
          if (q_req.size() != 0) begin
            r = q_req.pop_front();
            check(G, "m_req", {M_ADDR, M_WSTB, M_WDATA}, {r.a, r.s, r.d});
          end
        end
        if (!M_VALID) check(G, "m_idle_zero", {M_ADDR, M_WSTB, M_WDATA}, 0);
        if (|S_READY) begin
          check(G, "rsp_expected", q_rsp.size() != 0, 1);
          if (q_rsp.size() != 0) begin
            s = q_rsp.pop_front();
            check(G, "s_rsp", {S_READY, S_EXCEPT, S_RDATA},
                  {4'(1 << s.m), (s.e ? 4'(1 << s.m) : 4'h0), s.r});
          end
        end else begin
          check(G, "s_idle_zero", {S_EXCEPT, S_RDATA}, 0);
        end
        pv = M_VALID;
      end
    end

    initial begin : endc
      wait (end_chk);
      check(G, "req_queue_drained", q_req.size(), 0);
      check(G, "rsp_queue_drained", q_rsp.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin : main
    int k;
    #3;
    check(-1, "reset_outputs",
          {g_i[0].M_VALID, g_i[1].M_VALID, g_i[0].S_READY, g_i[1].S_READY}, 0);
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b1;

    req_rate = 30;  repeat (400) @(posedge CLK);
    req_rate = 100; repeat (300) @(posedge CLK);

    // Asynchronous reset while both instances hold a grant.
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (!(g_i[0].M_VALID && g_i[1].M_VALID) && k < 100);
    check(-1, "busy_before_reset", g_i[0].M_VALID && g_i[1].M_VALID, 1);
    #2 RST_N = 1'b0;
    #1;
    check(-1, "async_reset_outputs",
          {g_i[0].M_VALID, g_i[1].M_VALID, g_i[0].S_READY, g_i[1].S_READY}, 0);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b1;

    req_rate = 100; repeat (200) @(posedge CLK);
    req_rate = 50;  repeat (400) @(posedge CLK);
    req_rate = 0;   repeat (80)  @(posedge CLK);

    end_chk = 1'b1;
    wait (g_i[0].fin && g_i[1].fin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
